rv32i_hazard_scoreboard: RTL and testbench

RV32I_HAZARD_SCOREBOARD -- requirements
Module: rv32i_hazard_scoreboard

---
 rtl/rv32i_hazard_scoreboard_if.sv | 33 +++
 rtl/rv32i_hazard_scoreboard.sv | 128 ++++++++++++
 tb/tb_rv32i_hazard_scoreboard.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_hazard_scoreboard_if.sv
// Bundle between the operand-fetch stage and the hazard scoreboard.
// The master drives issue/result/query traffic; the slave answers with forwarding and stall.
interface rv32i_hazard_scoreboard_if #(
    parameter int XLEN       = 32,
    parameter int REG_BITS   = 5,
    parameter int STAGES     = 3,
    parameter int READ_PORTS = 2
) ();
    logic                            clear_i;
    logic                            advance_i;
    logic                            issue_i;
    logic [REG_BITS-1:0]             issue_rd_i;
    logic [STAGES-1:0]               result_valid_i;
    logic [STAGES*XLEN-1:0]          result_data_i;
    logic [READ_PORTS-1:0]           query_valid_i;
    logic [READ_PORTS*REG_BITS-1:0]  query_addr_i;
    logic [READ_PORTS-1:0]           fwd_hit_o;
    logic [READ_PORTS*XLEN-1:0]      fwd_data_o;
    logic                            stall_o;
    logic [$clog2(STAGES+1)-1:0]     in_flight_o;

    modport master (
        output clear_i, advance_i, issue_i, issue_rd_i,
        output result_valid_i, result_data_i, query_valid_i, query_addr_i,
        input  fwd_hit_o, fwd_data_o, stall_o, in_flight_o
    );

    modport slave (
        input  clear_i, advance_i, issue_i, issue_rd_i,
        input  result_valid_i, result_data_i, query_valid_i, query_addr_i,
        output fwd_hit_o, fwd_data_o, stall_o, in_flight_o
    );
endinterface

// File: rtl/rv32i_hazard_scoreboard.sv
// Tracks in-flight producers between opfetch and writeback; resolves RAW hazards per
// read port by forwarding the youngest matching ready result or stalling.
module rv32i_hazard_scoreboard #(
    parameter int XLEN       = 32,
    parameter int REG_BITS   = 5,
    parameter int STAGES     = 3,
    parameter int READ_PORTS = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    rv32i_hazard_scoreboard_if.slave bus
);
    localparam int CNT_W = $clog2(STAGES + 1);

    logic [STAGES-1:0]   valid_reg, valid_next;
    logic [STAGES-1:0]   ready_reg, ready_next;
    logic [REG_BITS-1:0] rd_reg   [STAGES];
    logic [REG_BITS-1:0] rd_next  [STAGES];
    logic [XLEN-1:0]     data_reg [STAGES];
    logic [XLEN-1:0]     data_next[STAGES];
    logic [CNT_W-1:0]    count_reg, count_next;

    // Slot contents after this cycle's result writes, before any shift
    logic [STAGES-1:0]   capture;
    logic [STAGES-1:0]   ready_post;
    logic [XLEN-1:0]     data_post[STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_slot
            assign capture[gi]    = bus.result_valid_i[gi] & valid_reg[gi];
            assign ready_post[gi] = ready_reg[gi] | capture[gi];
            assign data_post[gi]  = capture[gi] ? bus.result_data_i[gi*XLEN +: XLEN]
                                                : data_reg[gi];
        end
    endgenerate

    always_comb begin
        valid_next = valid_reg;
        ready_next = ready_post;
        rd_next    = rd_reg;
        data_next  = data_post;
        count_next = '0;
        if (bus.clear_i) begin
            valid_next = '0;
            ready_next = '0;
            for (int s = 0; s < STAGES; s++) begin
                rd_next[s]   = '0;
                data_next[s] = '0;
            end
        end else if (bus.advance_i) begin
            valid_next[0] = bus.issue_i & (bus.issue_rd_i != '0);
            rd_next[0]    = bus.issue_rd_i;
            ready_next[0] = 1'b0;
            data_next[0]  = '0;
            for (int s = 1; s < STAGES; s++) begin
                valid_next[s] = valid_reg[s-1];
                rd_next[s]    = rd_reg[s-1];
                ready_next[s] = ready_post[s-1];
                data_next[s]  = data_post[s-1];
            end
        end
        for (int s = 0; s < STAGES; s++) begin
            count_next = count_next + CNT_W'(valid_next[s]);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_reg <= '0;
            ready_reg <= '0;
            count_reg <= '0;
            for (int s = 0; s < STAGES; s++) begin
                rd_reg[s]   <= '0;
                data_reg[s] <= '0;
            end
        end else begin
            valid_reg <= valid_next;
            ready_reg <= ready_next;
            count_reg <= count_next;
            for (int s = 0; s < STAGES; s++) begin
                rd_reg[s]   <= rd_next[s];
                data_reg[s] <= data_next[s];
            end
        end
    end

    logic [READ_PORTS-1:0]      hit_vec;
    logic [READ_PORTS-1:0]      stall_vec;
    logic [READ_PORTS*XLEN-1:0] data_vec;

    generate
        for (gi = 0; gi < READ_PORTS; gi++) begin : g_port
            logic [REG_BITS-1:0] addr;
            logic                found;
            logic                sel_ready;
            logic [XLEN-1:0]     sel_data;

            assign addr = bus.query_addr_i[gi*REG_BITS +: REG_BITS];

            // Scan oldest to youngest so the youngest match is the one left standing
            always_comb begin
                found     = 1'b0;
                sel_ready = 1'b0;
                sel_data  = '0;
                for (int s = STAGES - 1; s >= 0; s--) begin
                    if (valid_reg[s] && (rd_reg[s] == addr)) begin
                        found     = 1'b1;
                        sel_ready = ready_reg[s];
                        sel_data  = data_reg[s];
                    end
                end
                if (addr == '0) begin
                    found = 1'b0;
                end
            end

            assign hit_vec[gi]                 = bus.query_valid_i[gi] & found & sel_ready;
            assign stall_vec[gi]               = bus.query_valid_i[gi] & found & ~sel_ready;
            assign data_vec[gi*XLEN +: XLEN]   = hit_vec[gi] ? sel_data : '0;
        end
    endgenerate

    assign bus.fwd_hit_o   = hit_vec;
    assign bus.fwd_data_o  = data_vec;
    assign bus.stall_o     = |stall_vec;
    assign bus.in_flight_o = count_reg;
endmodule

// File: tb/tb_rv32i_hazard_scoreboard.sv
// Directed bench: stimulus pushes hand-computed expectations, a negedge monitor pops
// and compares them against the scoreboard outputs.
module tb_rv32i_hazard_scoreboard;
    logic clk_i;
    logic reset_ni;

    rv32i_hazard_scoreboard_if #(.XLEN(32), .REG_BITS(5), .STAGES(3), .READ_PORTS(2)) bus ();

    rv32i_hazard_scoreboard #(.XLEN(32), .REG_BITS(5), .STAGES(3), .READ_PORTS(2)) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .bus      (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [1:0]  hit;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        stall;
        logic [1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;

    always @(negedge clk_i) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            compared++;
            if (bus.fwd_hit_o !== mon_e.hit || bus.fwd_data_o[31:0] !== mon_e.d0 ||
                bus.fwd_data_o[63:32] !== mon_e.d1 || bus.stall_o !== mon_e.stall ||
                bus.in_flight_o !== mon_e.cnt) begin
                mismatched++;
                $display("FAIL %s: got hit=%b d0=%h d1=%h stall=%b cnt=%0d, want hit=%b d0=%h d1=%h stall=%b cnt=%0d",
                         mon_e.name, bus.fwd_hit_o, bus.fwd_data_o[31:0], bus.fwd_data_o[63:32],
                         bus.stall_o, bus.in_flight_o, mon_e.hit, mon_e.d0, mon_e.d1,
                         mon_e.stall, mon_e.cnt);
            end else begin
                $display("ok   %s: hit=%b d0=%h d1=%h stall=%b cnt=%0d", mon_e.name,
                         bus.fwd_hit_o, bus.fwd_data_o[31:0], bus.fwd_data_o[63:32],
                         bus.stall_o, bus.in_flight_o);
            end
        end
    end

    task automatic idle();
        bus.clear_i        = 1'b0;
        bus.advance_i      = 1'b0;
        bus.issue_i        = 1'b0;
        bus.issue_rd_i     = '0;
        bus.result_valid_i = '0;
        bus.result_data_i  = '0;
        bus.query_valid_i  = '0;
        bus.query_addr_i   = '0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        bus.advance_i  = 1'b1;
        bus.issue_i    = 1'b1;
        bus.issue_rd_i = rd;
    endtask

    task automatic query(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1);
        bus.query_valid_i = v;
        bus.query_addr_i  = {a1, a0};
    endtask

    task automatic expect_now(input string name, input logic [1:0] hit, input logic [31:0] d0,
                              input logic [31:0] d1, input logic stall, input logic [1:0] cnt);
        exp_t e;
        e.name = name; e.hit = hit; e.d0 = d0; e.d1 = d1; e.stall = stall; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    initial begin
        reset_ni = 1'b0;
        idle();
        query(2'b11, 5'd5, 5'd5);
        expect_now("reset_idle", 2'b00, 0, 0, 1'b0, 2'd0);
        tick(); tick();
        reset_ni = 1'b1;
        idle();

        // RAW on a freshly issued producer, then forwarding once its result lands
        issue(5'd5);
        expect_now("issue5_pre", 2'b00, 0, 0, 1'b0, 2'd0);
        tick(); idle();
        query(2'b01, 5'd5, 5'd0);
        expect_now("raw_stall", 2'b00, 0, 0, 1'b1, 2'd1);
        bus.result_valid_i = 3'b001;
        bus.result_data_i  = {32'h0, 32'h0, 32'hDEADBEEF};
        expect_now("result_not_comb", 2'b00, 0, 0, 1'b1, 2'd1);
        tick(); idle();
        query(2'b01, 5'd5, 5'd0);
        expect_now("fwd_deadbeef", 2'b01, 32'hDEADBEEF, 0, 1'b0, 2'd1);

        // Ready entry travels to slot 1 on advance
        bus.advance_i = 1'b1;
        tick(); idle();
        query(2'b11, 5'd5, 5'd5);
        expect_now("travel_slot1", 2'b11, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2'd1);

        // Issue without advance is dropped
        bus.issue_i = 1'b1; bus.issue_rd_i = 5'd10;
        tick(); idle();
        query(2'b11, 5'd10, 5'd5);
        expect_now("issue_no_adv", 2'b10, 0, 32'hDEADBEEF, 1'b0, 2'd1);

        bus.clear_i = 1'b1;
        tick(); idle();
        query(2'b11, 5'd5, 5'd5);
        expect_now("clear_flush", 2'b00, 0, 0, 1'b0, 2'd0);

        // Younger non-ready match hides an older ready one
        idle(); issue(5'd7); tick();
        idle(); issue(5'd7); tick();
        idle();
        bus.result_valid_i = 3'b010;
        bus.result_data_i  = {32'h0, 32'h11, 32'h0};
        tick(); idle();
        query(2'b01, 5'd7, 5'd0);
        expect_now("young_not_ready", 2'b00, 0, 0, 1'b1, 2'd2);
        bus.result_valid_i = 3'b001;
        bus.result_data_i  = {32'h0, 32'h0, 32'h22};
        tick(); idle();
        query(2'b01, 5'd7, 5'd0);
        expect_now("young_ready", 2'b01, 32'h22, 0, 1'b0, 2'd2);
        bus.result_valid_i = 3'b001;
        bus.result_data_i  = {32'h0, 32'h0, 32'h33};
        tick(); idle();
        query(2'b01, 5'd7, 5'd0);
        expect_now("overwrite", 2'b01, 32'h33, 0, 1'b0, 2'd2);

        // Fill and retire
        bus.clear_i = 1'b1; tick(); idle();
        issue(5'd1); tick(); idle();
        query(2'b01, 5'd1, 5'd0);
        expect_now("count1", 2'b00, 0, 0, 1'b1, 2'd1);
        issue(5'd2); tick(); idle();
        query(2'b01, 5'd1, 5'd0);
        expect_now("count2", 2'b00, 0, 0, 1'b1, 2'd2);
        issue(5'd3); tick(); idle();
        query(2'b01, 5'd1, 5'd0);
        expect_now("count3", 2'b00, 0, 0, 1'b1, 2'd3);
        bus.advance_i = 1'b1; tick(); idle();
        query(2'b11, 5'd1, 5'd3);
        expect_now("rd1_retired", 2'b00, 0, 0, 1'b1, 2'd2);
        bus.advance_i      = 1'b1;
        bus.result_valid_i = 3'b110;
        bus.result_data_i  = {32'h55, 32'h33, 32'h0};
        tick(); idle();
        query(2'b11, 5'd2, 5'd3);
        expect_now("travel_and_retire", 2'b10, 0, 32'h33, 1'b0, 2'd1);

        // rd=0 issue is a bubble; address 0 never hits or stalls
        bus.clear_i = 1'b1; tick(); idle();
        issue(5'd4); tick(); idle();
        issue(5'd0); tick(); idle();
        query(2'b10, 5'd0, 5'd0);
        expect_now("rd0_bubble", 2'b00, 0, 0, 1'b0, 2'd1);

        // Clear outranks a simultaneous advance+issue
        bus.clear_i = 1'b1; issue(5'd9);
        tick(); idle();
        query(2'b01, 5'd9, 5'd0);
        expect_now("clear_priority", 2'b00, 0, 0, 1'b0, 2'd0);

        // Asynchronous reset mid-stream
        issue(5'd6); tick(); idle();
        bus.result_valid_i = 3'b001;
        bus.result_data_i  = {32'h0, 32'h0, 32'h66};
        tick(); idle();
        query(2'b01, 5'd6, 5'd0);
        expect_now("pre_reset_hit", 2'b01, 32'h66, 0, 1'b0, 2'd1);
        tick();
        reset_ni = 1'b0;
        expect_now("reset_async", 2'b00, 0, 0, 1'b0, 2'd0);
        tick();
        reset_ni = 1'b1;
        issue(5'd8);
        expect_now("post_reset_empty", 2'b00, 0, 0, 1'b0, 2'd0);
        tick(); idle();
        query(2'b01, 5'd8, 5'd0);
        expect_now("first_edge_normal", 2'b00, 0, 0, 1'b1, 2'd1);

        tick(); idle();
        @(negedge clk_i);
        #1;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
